// File: rtl/bist_pkg.sv
// Shared types for the BIST engine: FSM state encoding
// and the zero-seed-safe LFSR seed helper.
package bist_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_CMP   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    INIT    = ST_INIT,
    RUN     = ST_RUN,
    FLUSH   = ST_FLUSH,
    COMPARE = ST_CMP,
    DONE    = ST_DONE
  } bist_state_e;

  // An all-zero LFSR would lock up, so zero maps to 1.
  function automatic logic [63:0] safe_seed(input logic [63:0] s);
    return (s == '0) ? 64'd1 : s;
  endfunction

endpackage

// File: rtl/bist_engine_if.sv
// CUT-side bus of the BIST engine: stimulus, reset and
// responses between the engine (master) and the CUT (slave).
interface bist_engine_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
);

  logic [N_IN-1:0]  dut_in_o;
  logic [N_OUT-1:0] dut_out_i;
  logic             dut_reset_o;

  modport master (
    output dut_in_o,
    output dut_reset_o,
    input  dut_out_i
  );

  modport slave (
    input  dut_in_o,
    input  dut_reset_o,
    output dut_out_i
  );

endinterface

// File: rtl/bist_sig_reg.sv
// Shift register with XOR feedback and parallel XOR input;
// serves as the pattern LFSR (din = 0) and the response MISR.
module bist_sig_reg #(
  parameter int           W    = 16,
  parameter logic [W-1:0] POLY = '0
) (
  input  logic         clock,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (load)
      q <= load_val;
    else if (en)
      q <= {q[W-2:0], ^(q & POLY)} ^ din;
  end

endmodule

// File: rtl/bist_engine.sv
// Parametrised BIST harness: LFSR stimulus, aligned MISR capture,
// golden compare. `BIST_SIG_READOUT_EN adds the signature_o port.
module bist_engine
  import bist_pkg::*;
#(
  parameter int                N_IN       = 4,
  parameter int                N_OUT      = 4,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_POLY  = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'h0001,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = 16'hB400,
  parameter int                PATTERNS   = 256,
  parameter int                CUT_LAT    = 1,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [N_IN-1:0]   req_i,
  bist_engine_if.master     cut,
  output logic              busy,
  output logic              bist_end,
  output logic              pass_fail
`ifdef BIST_SIG_READOUT_EN
  ,
  output logic [MISR_W-1:0] signature_o
`endif
);

  localparam int MAX_C = (PATTERNS > CUT_LAT) ? PATTERNS : CUT_LAT;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [LFSR_W-1:0] SEED =
    LFSR_W'(safe_seed(64'(LFSR_SEED)));

  bist_state_e       state;
  bist_state_e       state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [LFSR_W-1:0] lfsr;
  logic [MISR_W-1:0] misr;
  logic [MISR_W-1:0] misr_din;
  logic              clr;
  logic              run_last;
  logic              flush_last;
  logic              cap;
  logic              lfsr_unused;

  assign clr        = reset | (state == INIT);
  assign run_last   = (cnt == CNT_W'(PATTERNS - 1));
  assign flush_last = (CUT_LAT == 0) ||
                      (cnt == CNT_W'(CUT_LAT - 1));

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    bist_end = 1'b0;
    unique case (state)
      IDLE: if (start) state_nx = INIT;
      INIT: begin
        busy     = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (run_last) begin
          if (CUT_LAT == 0)
            state_nx = COMPARE;
          else
            state_nx = FLUSH;
        end
      end
      FLUSH: begin
        busy = 1'b1;
        if (flush_last) state_nx = COMPARE;
      end
      COMPARE: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        bist_end = 1'b1;
        if (start) state_nx = INIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One counter serves RUN (patterns) and FLUSH (latency drain).
  always_ff @(posedge clock) begin
    if (clr)
      cnt <= '0;
    else if (state == RUN)
      cnt <= run_last ? '0 : cnt + 1'b1;
    else if (state == FLUSH)
      cnt <= cnt + 1'b1;
  end

  // Capture strobe: the RUN flag delayed to line up with CUT output.
  if (CUT_LAT == 0) begin : g_nolat
    assign cap = (state == RUN);
  end else begin : g_lat
    logic [CUT_LAT-1:0] vld;
    always_ff @(posedge clock) begin
      if (clr)
        vld <= '0;
      else
        vld <= (vld << 1) | CUT_LAT'(state == RUN);
    end
    assign cap = vld[CUT_LAT-1];
  end

  always_comb begin
    misr_din              = '0;
    misr_din[N_OUT-1:0]   = cut.dut_out_i;
  end

  // Last pattern is held by not stepping on the final RUN cycle.
  bist_sig_reg #(
    .W    (LFSR_W),
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clock    (clock),
    .load     (clr),
    .load_val (SEED),
    .en       ((state == RUN) && !run_last),
    .din      ('0),
    .q        (lfsr)
  );

  bist_sig_reg #(
    .W    (MISR_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clock    (clock),
    .load     (clr),
    .load_val ('0),
    .en       (cap),
    .din      (misr_din),
    .q        (misr)
  );

  assign lfsr_unused = ^lfsr;

  always_ff @(posedge clock) begin
    if (clr)
      pass_fail <= 1'b0;
    else if (state == COMPARE)
      pass_fail <= (misr == GOLDEN_SIG);
  end

  assign cut.dut_in_o =
    ((state == IDLE) || (state == DONE)) ? req_i : lfsr[N_IN-1:0];
  assign cut.dut_reset_o = reset | (state == INIT);

`ifdef BIST_SIG_READOUT_EN
  always_ff @(posedge clock) begin
    if (reset)
      signature_o <= '0;
    else if (busy)
      signature_o <= misr;
  end
`endif

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine: two small instances
// (seed 1 / latency 1 and seed 0 / latency 0) against a model.
module tb_bist_engine;

  localparam int P = 8;

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] ref_sig(input int seed,
                                          input int fk,
                                          input int fm,
                                          input int k);
    int p;
    int m;
    int r;
    int t;
    int par;
    p = (seed == 0) ? 1 : seed;
    m = 0;
    for (int i = 0; i < 8; i++) begin
      r = p ^ k ^ ((i == fk) ? fm : 0);
      t = m & 'hB400;
      par = 0;
      for (int b = 0; b < 16; b++) par = par ^ ((t >> b) & 1);
      m = ((m << 1) & 'hFFFF) | par;
      m = m ^ (r & 'hF);
      t = p & 9;
      par = 0;
      for (int b = 0; b < 4; b++) par = par ^ ((t >> b) & 1);
      p = ((p << 1) & 'hF) | par;
    end
    return m[15:0];
  endfunction

  function automatic logic [3:0] pat(input int seed, input int idx);
    int p;
    int t;
    int par;
    p = (seed == 0) ? 1 : seed;
    for (int i = 0; i < idx; i++) begin
      t = p & 9;
      par = 0;
      for (int b = 0; b < 4; b++) par = par ^ ((t >> b) & 1);
      p = ((p << 1) & 'hF) | par;
    end
    return p[3:0];
  endfunction

  localparam logic [15:0] GOLD = ref_sig(1, 0, 0, 0);

  logic       clock = 1'b0;
  logic [1:0] rst;
  logic [1:0] st;
  logic [1:0] busy;
  logic [1:0] bend;
  logic [1:0] pf;
  logic [1:0] drst;
  logic [3:0] req  [2];
  logic [3:0] flip [2];
  logic [3:0] key  [2];
  logic [3:0] din  [2];
  logic [3:0] reg_a;
`ifdef BIST_SIG_READOUT_EN
  logic [15:0] sig [2];
`endif

  always #5 clock = ~clock;

  bist_engine_if #(.N_IN(4), .N_OUT(4)) cut_a ();
  bist_engine_if #(.N_IN(4), .N_OUT(4)) cut_b ();

  assign din[0]  = cut_a.dut_in_o;
  assign drst[0] = cut_a.dut_reset_o;
  assign din[1]  = cut_b.dut_in_o;
  assign drst[1] = cut_b.dut_reset_o;

  always @(posedge clock) reg_a <= din[0];

  assign cut_a.dut_out_i = reg_a ^ flip[0] ^ key[0];
  assign cut_b.dut_out_i = din[1] ^ flip[1] ^ key[1];

  bist_engine #(
    .N_IN(4), .N_OUT(4), .LFSR_W(4), .LFSR_POLY(4'b1001),
    .LFSR_SEED(4'b0001), .MISR_W(16), .MISR_POLY(16'hB400),
    .PATTERNS(P), .CUT_LAT(1), .GOLDEN_SIG(GOLD)
  ) dut_a (
    .clock(clock), .reset(rst[0]), .start(st[0]),
    .req_i(req[0]), .cut(cut_a), .busy(busy[0]),
    .bist_end(bend[0]), .pass_fail(pf[0])
`ifdef BIST_SIG_READOUT_EN
    , .signature_o(sig[0])
`endif
  );

  bist_engine #(
    .N_IN(4), .N_OUT(4), .LFSR_W(4), .LFSR_POLY(4'b1001),
    .LFSR_SEED(4'b0000), .MISR_W(16), .MISR_POLY(16'hB400),
    .PATTERNS(P), .CUT_LAT(0), .GOLDEN_SIG(GOLD)
  ) dut_b (
    .clock(clock), .reset(rst[1]), .start(st[1]),
    .req_i(req[1]), .cut(cut_b), .busy(busy[1]),
    .bist_end(bend[1]), .pass_fail(pf[1])
`ifdef BIST_SIG_READOUT_EN
    , .signature_o(sig[1])
`endif
  );

  task automatic chk(input string tag, input int d,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h",
             tag, d, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // n counts cycles from the one in which start is first sampled.
  task automatic run(input int d, input int fk,
                     input logic [3:0] fm, input logic [3:0] k,
                     input bit hold, input bit from_done,
                     input int abort_at);
    int lat;
    int endc;
    int seed;
    logic [15:0] exp_sig;
    lat     = (d == 0) ? 1 : 0;
    seed    = (d == 0) ? 1 : 0;
    endc    = 3 + P + lat;
    exp_sig = ref_sig(seed, fk, int'(fm), int'(k));
    key[d]  = k;
    for (int n = 0; n <= endc; n++) begin
      st[d]   = (n == 0) || (hold && n <= P + 1);
      flip[d] = (n == 2 + fk + lat) ? fm : 4'h0;
      req[d]  = 4'($urandom_range(0, 15));
      rst[d]  = (n == abort_at);
      #2;
      if (n == abort_at) begin
        chk("abort_dut_reset", d, drst[d], 1);
        tick();
        rst[d]  = 1'b0;
        st[d]   = 1'b0;
        flip[d] = 4'h0;
        #2;
        chk("abort_busy", d, busy[d], 0);
        chk("abort_bist_end", d, bend[d], 0);
        chk("abort_pass_fail", d, pf[d], 0);
        chk("abort_passthru", d, din[d], req[d]);
        tick();
        return;
      end
      chk("busy", d, busy[d], (n >= 1) && (n < endc));
      chk("bist_end", d, bend[d],
          (n == endc) || (n == 0 && from_done));
      chk("dut_reset", d, drst[d], n == 1);
      if (n == 0 || n == endc)
        chk("passthru", d, din[d], req[d]);
      if (n >= 2 && n <= P + 1)
        chk("pattern", d, din[d], pat(seed, n - 2));
      if (lat > 0 && n >= P + 2 && n < P + 2 + lat)
        chk("flush_hold", d, din[d], pat(seed, P - 1));
      if (n == endc) begin
        chk("pass_fail", d, pf[d], exp_sig == GOLD);
`ifdef BIST_SIG_READOUT_EN
        chk("signature", d, sig[d], exp_sig);
`endif
      end
      tick();
    end
    st[d]   = 1'b0;
    flip[d] = 4'h0;
  endtask

  initial begin
    rst = 2'b11;
    st  = 2'b00;
    for (int d = 0; d < 2; d++) begin
      req[d]  = 4'hA;
      flip[d] = 4'h0;
      key[d]  = 4'h0;
    end
    tick();
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", d, busy[d], 0);
      chk("rst_bist_end", d, bend[d], 0);
      chk("rst_pass_fail", d, pf[d], 0);
      chk("rst_dut_reset", d, drst[d], 1);
      chk("rst_passthru", d, din[d], 4'hA);
    end
    tick();
    rst = 2'b00;
    tick();

    run(0, 0, 4'h0, 4'h0, 1'b0, 1'b0, -1);
    run(0, int'($urandom_range(0, P - 1)),
        4'(1 << $urandom_range(0, 3)), 4'h0, 1'b0, 1'b1, -1);
    run(0, 0, 4'h0, 4'h0, 1'b1, 1'b1, -1);
    run(0, 0, 4'h0, 4'h0, 1'b0, 1'b1, 5);
    run(0, 0, 4'h0, 4'h0, 1'b0, 1'b0, -1);

    run(1, 0, 4'h0, 4'h0, 1'b0, 1'b0, -1);
    run(1, int'($urandom_range(0, P - 1)),
        4'(1 << $urandom_range(0, 3)), 4'h0, 1'b0, 1'b1, -1);
    run(1, 0, 4'h0, 4'($urandom_range(1, 15)),
        1'b0, 1'b1, -1);
    run(1, 0, 4'h0, 4'h0, 1'b1, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_engine.md
Name: bist_engine

Overview:
Parametrised, self-contained BIST harness that generalises our fixed 4-request LFSR/controller/MISR wrapper. It wraps any combinational or pipelined circuit under test (CUT) with N_IN inputs and N_OUT outputs. It muxes LFSR patterns onto the CUT inputs, compacts aligned CUT responses in a MISR, and compares the result against a golden signature. The CUT itself stays outside; the engine sits between the top-level functional IO and the CUT.

Parameters:
N_IN, 4, CUT input count; must satisfy N_IN <= LFSR_W
N_OUT, 4, CUT output count; must satisfy N_OUT <= MISR_W
LFSR_W, 16, pattern generator width
LFSR_POLY, 16'hB400, feedback tap mask for the LFSR
LFSR_SEED, 16'h0001, LFSR load value; an all-zero seed is replaced by 1
MISR_W, 16, signature register width
MISR_POLY, 16'hB400, feedback tap mask for the MISR
PATTERNS, 256, number of patterns applied; must be >= 1
CUT_LAT, 1, CUT input-to-output latency in cycles; must be >= 0
GOLDEN_SIG, 16'h0000, expected final MISR value

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level-sampled run request
req_i  in  N_IN  functional CUT inputs
dut_in_o  out  N_IN  inputs driven to the CUT
dut_out_i  in  N_OUT  responses returned from the CUT
dut_reset_o  out  1  reset driven to the CUT
busy  out  1  high while a test is in progress
bist_end  out  1  test complete
pass_fail  out  1  1 = signature match; valid only while bist_end = 1

Behaviour:
- Clocking and reset: one clock (clock); reset is synchronous and active-high. Reset has priority over everything, including a test in progress.
  - Reset forces state IDLE, busy = 0, bist_end = 0, pass_fail = 0.
  - LFSR loads the seed; MISR = 0; the alignment pipeline is cleared.
- States: IDLE, INIT, RUN, FLUSH, COMPARE, DONE.
- IDLE: start = 1 sampled goes to INIT next cycle.
- INIT (1 cycle):
  - LFSR loads the seed (zero seed becomes 1); MISR clears; pattern counter clears.
  - dut_reset_o = 1.
- RUN (exactly PATTERNS cycles):
  - dut_in_o = lfsr[N_IN-1:0].
  - LFSR steps each cycle: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_POLY)}.
  - Counter reaches PATTERNS-1 goes to FLUSH, or to COMPARE when CUT_LAT = 0.
- FLUSH (CUT_LAT cycles): dut_in_o holds the last pattern; the LFSR is frozen.
- Capture alignment:
  - A valid bit is issued for every RUN cycle and delayed by CUT_LAT flops.
  - When the delayed valid is set: misr <= {misr[MISR_W-2:0], ^(misr & MISR_POLY)} ^ zero_extend(dut_out_i).
  - Exactly PATTERNS responses are compacted.
- COMPARE (1 cycle): registers pass_fail = (misr == GOLDEN_SIG).
- DONE:
  - bist_end = 1; pass_fail is held.
  - start = 1 sampled goes to INIT, a rerun that clears bist_end the next cycle.
- busy = 1 in INIT, RUN, FLUSH and COMPARE.
- dut_in_o = req_i in IDLE and DONE (functional pass-through); LFSR-driven in INIT, RUN and FLUSH.
- dut_reset_o = reset | (state == INIT).
- start is ignored while busy = 1.
- Total latency: start sampled in cycle t puts bist_end high in cycle t + 2 + PATTERNS + CUT_LAT + 1.

Optional Feature:
BIST_SIG_READOUT_EN
- Defined: adds output signature_o [MISR_W-1:0], which carries the live MISR value. It is registered, 0 on reset, and frozen from COMPARE until the next INIT. Used for golden-signature extraction during bring-up.
- Undefined: the port is absent and the signature is not observable; all other behaviour is identical.

Decomposition:
- Package bist_pkg holds:
  - the state enum typedef;
  - the localparam state encodings;
  - a function computing a zero-seed-safe seed.
- One natural sub-module: bist_sig_reg, a parametrised shift register with XOR feedback and a parallel XOR input. Parameters are W and POLY; ports are load, load_val, en, din.
  - Instantiated twice: as the LFSR with din = 0, and as the MISR with din = dut_out_i.
- The FSM, counter and alignment pipeline live in bist_engine.

Test Plan:
- Reset check: assert reset for 2 cycles -> busy = 0, bist_end = 0, pass_fail = 0, dut_reset_o = 1, dut_in_o == req_i (req_i = 4'hA gives 4'hA).
- Pattern sequence (LFSR_W=4, LFSR_POLY=4'b1001, LFSR_SEED=4'b0001, N_IN=4, PATTERNS=8, CUT_LAT=1), start pulsed at t0:
  - dut_reset_o = 1 at t1;
  - dut_in_o = 0001, 0011, 0111 at t2, t3, t4;
  - bist_end = 1 at t12.
- Pass path: CUT = identity with a 1-cycle register, GOLDEN_SIG taken from the bench reference model -> pass_fail = 1 in DONE. Flipping one bit of dut_out_i on any single capture cycle -> pass_fail = 0.
- Zero seed and zero latency: LFSR_SEED=0, CUT_LAT=0 -> first pattern = 0001; FLUSH is skipped, so bist_end rises at t0 + 2 + PATTERNS + 1.
- Reset mid-run: assert reset at t5 -> next cycle IDLE, busy = 0. A new start then gives a full rerun with a signature identical to an uninterrupted run.
- Start handling:
  - start held high through RUN -> no restart and latency unchanged;
  - start = 1 in DONE -> bist_end = 0 next cycle and a rerun follows.
